// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order load/store issue queue with operand wakeup,
// dual in-order issue to the memory stage and active-list recall squash.
// Ports: clk, rst_n (async, active low); if_recall/new_front/old_front
// give the squash range; i_disp_* are two dispatch lanes (lane 0 older)
// gated by o_disp_ready; i_wb_* are two wakeup lanes; o_iss_* are two
// registered issue lanes (lane 0 older).
// Optional build macro MIQ_STALL_CNT_EN adds o_stall_cnt (16-bit,
// saturating count of cycles with a valid but unready head entry).
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module mem_issue_queue #(
    parameter int MIQ_DEPTH = 8,
    parameter int PREG_W    = 6,
    parameter int AL_W      = $clog2(`AL_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_recall,
    input  logic [AL_W-1:0]        new_front,
    input  logic [AL_W-1:0]        old_front,
    input  logic [1:0]             i_disp_valid,
    input  logic [1:0]             i_disp_type,
    input  logic [1:0][PREG_W-1:0] i_disp_rd,
    input  logic [1:0][PREG_W-1:0] i_disp_rs1,
    input  logic [1:0][PREG_W-1:0] i_disp_rs2,
    input  logic [1:0]             i_disp_rs1_rdy,
    input  logic [1:0]             i_disp_rs2_rdy,
    input  logic [1:0][31:0]       i_disp_imm,
    input  logic [1:0][AL_W-1:0]   i_disp_al_addr,
    output logic                   o_disp_ready,
    input  logic [1:0]             i_wb_valid,
    input  logic [1:0]             i_wb_uses_rd,
    input  logic [1:0][PREG_W-1:0] i_wb_rd,
    output logic [1:0]             o_iss_valid,
    output logic [1:0]             o_iss_type,
    output logic [1:0][PREG_W-1:0] o_iss_rd,
    output logic [1:0][PREG_W-1:0] o_iss_rs1,
    output logic [1:0][PREG_W-1:0] o_iss_rs2,
    output logic [1:0][31:0]       o_iss_imm,
    output logic [1:0][AL_W-1:0]   o_iss_al_addr
`ifdef MIQ_STALL_CNT_EN
    ,
    output logic [15:0]            o_stall_cnt
`endif
);

    localparam int PW = $clog2(MIQ_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    ptr_t head, tail, h1;
    cnt_t count, n_enq, n_iss, sq_off;

    logic [MIQ_DEPTH-1:0] ent_v, v_nxt, ent_ok, sq_mask;
    logic [MIQ_DEPTH-1:0] ent_type, ent_r1, ent_r2;
    logic [PREG_W-1:0]    ent_rd  [MIQ_DEPTH];
    logic [PREG_W-1:0]    ent_rs1 [MIQ_DEPTH];
    logic [PREG_W-1:0]    ent_rs2 [MIQ_DEPTH];
    logic [31:0]          ent_imm [MIQ_DEPTH];
    logic [AL_W-1:0]      ent_al  [MIQ_DEPTH];
    logic [AL_W-1:0]      al_off  [MIQ_DEPTH];
    logic [AL_W-1:0]      rec_span;

    logic [1:0] iss, we;
    ptr_t       isrc [2];
    ptr_t       widx [2];

    function automatic logic wb_hit(input logic [PREG_W-1:0] tag);
        logic h;
        h = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (i_wb_valid[w] && i_wb_uses_rd[w] && i_wb_rd[w] == tag)
                h = 1'b1;
        end
        return h;
    endfunction

    assign o_disp_ready = (cnt_t'(MIQ_DEPTH) - count) >= cnt_t'(2);

    assign h1      = head + ptr_t'(1);
    assign isrc[0] = head;
    assign isrc[1] = h1;

    // Readiness uses stored bits only, so a wakeup takes one extra edge.
    always_comb begin
        rec_span = old_front - new_front;
        for (int e = 0; e < MIQ_DEPTH; e++) begin
            ent_ok[e]  = ent_v[e] & ent_r1[e] & (~ent_type[e] | ent_r2[e]);
            al_off[e]  = ent_al[e] - new_front;
            sq_mask[e] = ent_v[e] & (al_off[e] < rec_span);
        end
    end

    assign iss[0] = ~if_recall & ent_ok[head];
    assign iss[1] = iss[0] & ent_ok[h1];
    assign we     = {2{~if_recall & o_disp_ready}} & i_disp_valid;

    assign widx[0] = tail;
    assign widx[1] = tail + ptr_t'(we[0]);

    assign n_iss = cnt_t'(iss[0]) + cnt_t'(iss[1]);
    assign n_enq = cnt_t'(we[0]) + cnt_t'(we[1]);

    // Age offset of the oldest squashed entry; equals count if none.
    always_comb begin
        sq_off = count;
        for (int i = MIQ_DEPTH - 1; i >= 0; i--) begin
            if (sq_mask[head + ptr_t'(i)])
                sq_off = cnt_t'(i);
        end
    end

    always_comb begin
        v_nxt = ent_v;
        if (if_recall) begin
            v_nxt = ent_v & ~sq_mask;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (iss[l]) v_nxt[isrc[l]] = 1'b0;
            end
            for (int l = 0; l < 2; l++) begin
                if (we[l]) v_nxt[widx[l]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ent_v         <= '0;
            o_iss_valid   <= '0;
            o_iss_type    <= '0;
            o_iss_rd      <= '0;
            o_iss_rs1     <= '0;
            o_iss_rs2     <= '0;
            o_iss_imm     <= '0;
            o_iss_al_addr <= '0;
        end else begin
            ent_v       <= v_nxt;
            o_iss_valid <= iss;
            if (if_recall) begin
                tail  <= head + sq_off[PW-1:0];
                count <= sq_off;
            end else begin
                head  <= head + n_iss[PW-1:0];
                tail  <= tail + n_enq[PW-1:0];
                count <= count + n_enq - n_iss;
            end
            for (int l = 0; l < 2; l++) begin
                if (iss[l]) begin
                    o_iss_type[l]    <= ent_type[isrc[l]];
                    o_iss_rd[l]      <= ent_rd[isrc[l]];
                    o_iss_rs1[l]     <= ent_rs1[isrc[l]];
                    o_iss_rs2[l]     <= ent_rs2[isrc[l]];
                    o_iss_imm[l]     <= ent_imm[isrc[l]];
                    o_iss_al_addr[l] <= ent_al[isrc[l]];
                end
            end
        end
    end

    // Payload carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        for (int e = 0; e < MIQ_DEPTH; e++) begin
            ent_r1[e] <= ent_r1[e] | wb_hit(ent_rs1[e]);
            ent_r2[e] <= ent_r2[e] | wb_hit(ent_rs2[e]);
            for (int l = 0; l < 2; l++) begin
                if (we[l] && widx[l] == ptr_t'(e)) begin
                    ent_type[e] <= i_disp_type[l];
                    ent_rd[e]   <= i_disp_rd[l];
                    ent_rs1[e]  <= i_disp_rs1[l];
                    ent_rs2[e]  <= i_disp_rs2[l];
                    ent_imm[e]  <= i_disp_imm[l];
                    ent_al[e]   <= i_disp_al_addr[l];
                    ent_r1[e]   <= i_disp_rs1_rdy[l] | wb_hit(i_disp_rs1[l]);
                    ent_r2[e]   <= i_disp_rs2_rdy[l] | wb_hit(i_disp_rs2[l]);
                end
            end
        end
    end

`ifdef MIQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_stall_cnt <= '0;
        else if (ent_v[head] && !ent_ok[head] && o_stall_cnt != 16'hFFFF)
            o_stall_cnt <= o_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mem_issue_queue.sv
// tb_mem_issue_queue: directed scenarios plus a randomized run checked
// against a queue-based reference model of the issue queue.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module tb_mem_issue_queue;

    localparam int DEPTH = 8;
    localparam int PW    = 6;
    localparam int ALN   = `AL_SIZE;
    localparam int AW    = $clog2(`AL_SIZE);
    localparam logic RD  = 1'b0;
    localparam logic WR  = 1'b1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                if_recall;
    logic [AW-1:0]       new_front, old_front;
    logic [1:0]          i_disp_valid, i_disp_type;
    logic [1:0][PW-1:0]  i_disp_rd, i_disp_rs1, i_disp_rs2;
    logic [1:0]          i_disp_rs1_rdy, i_disp_rs2_rdy;
    logic [1:0][31:0]    i_disp_imm;
    logic [1:0][AW-1:0]  i_disp_al_addr;
    logic                o_disp_ready;
    logic [1:0]          i_wb_valid, i_wb_uses_rd;
    logic [1:0][PW-1:0]  i_wb_rd;
    logic [1:0]          o_iss_valid, o_iss_type;
    logic [1:0][PW-1:0]  o_iss_rd, o_iss_rs1, o_iss_rs2;
    logic [1:0][31:0]    o_iss_imm;
    logic [1:0][AW-1:0]  o_iss_al_addr;
`ifdef MIQ_STALL_CNT_EN
    logic [15:0]         o_stall_cnt;
`endif

    int vec  = 0;
    int errs = 0;

    mem_issue_queue #(.MIQ_DEPTH(DEPTH), .PREG_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .if_recall(if_recall),
        .new_front(new_front), .old_front(old_front),
        .i_disp_valid(i_disp_valid), .i_disp_type(i_disp_type),
        .i_disp_rd(i_disp_rd), .i_disp_rs1(i_disp_rs1),
        .i_disp_rs2(i_disp_rs2), .i_disp_rs1_rdy(i_disp_rs1_rdy),
        .i_disp_rs2_rdy(i_disp_rs2_rdy), .i_disp_imm(i_disp_imm),
        .i_disp_al_addr(i_disp_al_addr), .o_disp_ready(o_disp_ready),
        .i_wb_valid(i_wb_valid), .i_wb_uses_rd(i_wb_uses_rd),
        .i_wb_rd(i_wb_rd), .o_iss_valid(o_iss_valid),
        .o_iss_type(o_iss_type), .o_iss_rd(o_iss_rd),
        .o_iss_rs1(o_iss_rs1), .o_iss_rs2(o_iss_rs2),
        .o_iss_imm(o_iss_imm), .o_iss_al_addr(o_iss_al_addr)
`ifdef MIQ_STALL_CNT_EN
        , .o_stall_cnt(o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          t;
        logic [PW-1:0] rd, rs1, rs2;
        logic          r1, r2;
        logic [31:0]   imm;
        logic [AW-1:0] al;
    } op_t;

    task automatic clr();
        if_recall = 0; new_front = '0; old_front = '0;
        i_disp_valid = '0; i_disp_type = '0; i_disp_rd = '0;
        i_disp_rs1 = '0; i_disp_rs2 = '0; i_disp_rs1_rdy = '0;
        i_disp_rs2_rdy = '0; i_disp_imm = '0; i_disp_al_addr = '0;
        i_wb_valid = '0; i_wb_uses_rd = '0; i_wb_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic put(input int l, input logic t, input logic [PW-1:0] rs1,
                       input logic r1, input logic r2, input int al);
        i_disp_valid[l]   = 1'b1;
        i_disp_type[l]    = t;
        i_disp_rd[l]      = PW'(al + 1);
        i_disp_rs1[l]     = rs1;
        i_disp_rs2[l]     = 6'd50;
        i_disp_rs1_rdy[l] = r1;
        i_disp_rs2_rdy[l] = r2;
        i_disp_imm[l]     = 32'h1000 + al;
        i_disp_al_addr[l] = AW'(al);
    endtask

    task automatic wake(input int l, input logic [PW-1:0] rd, input logic uses);
        i_wb_valid[l]   = 1'b1;
        i_wb_uses_rd[l] = uses;
        i_wb_rd[l]      = rd;
    endtask

    task automatic test_reset();
        clr();
        rst_n = 0;
        tick();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL reset_valid got %b want 00", o_iss_valid); end
        vec++; if (o_disp_ready !== 1'b1) begin errs++;
            $display("FAIL reset_ready got %b want 1", o_disp_ready); end
        vec++; if (o_iss_imm !== '0 || o_iss_al_addr !== '0) begin errs++;
            $display("FAIL reset_fields got %h/%h want 0", o_iss_imm, o_iss_al_addr); end
`ifdef MIQ_STALL_CNT_EN
        vec++; if (o_stall_cnt !== 16'd0) begin errs++;
            $display("FAIL reset_stall got %0d want 0", o_stall_cnt); end
`endif
        rst_n = 1;
        tick();
        tick();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL reset_idle got %b want 00", o_iss_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        put(0, RD, 6'd1, 1, 0, 1);
        put(1, RD, 6'd40, 0, 0, 2);
        tick();
        clr();
        tick();
        vec++; if (o_iss_valid !== 2'b01) begin errs++;
            $display("FAIL mid_pre got %b want 01", o_iss_valid); end
        #2 rst_n = 0;
        #1;
        vec++; if (o_iss_valid !== 2'b00 || o_disp_ready !== 1'b1) begin errs++;
            $display("FAIL mid_async got %b/%b want 00/1", o_iss_valid, o_disp_ready); end
        tick();
        rst_n = 1;
        wake(0, 6'd40, 1);
        tick();
        clr();
        tick();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL mid_discard got %b want 00", o_iss_valid); end
    endtask

    task automatic test_dual_issue();
        do_reset();
        put(0, RD, 6'd7, 1, 0, 3);
        put(1, WR, 6'd8, 1, 1, 4);
        tick();
        clr();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL dual_early got %b want 00", o_iss_valid); end
        tick();
        vec++; if (o_iss_valid !== 2'b11) begin errs++;
            $display("FAIL dual_valid got %b want 11", o_iss_valid); end
        vec++; if (o_iss_al_addr[0] !== AW'(3) || o_iss_al_addr[1] !== AW'(4)) begin errs++;
            $display("FAIL dual_al got %0d,%0d want 3,4", o_iss_al_addr[0], o_iss_al_addr[1]); end
        vec++; if (o_iss_type !== 2'b10 || o_iss_imm[1] !== 32'h1004) begin errs++;
            $display("FAIL dual_fields got %b/%h want 10/1004", o_iss_type, o_iss_imm[1]); end
        tick();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL dual_after got %b want 00", o_iss_valid); end
    endtask

    task automatic test_wakeup();
        do_reset();
        put(0, RD, 6'd12, 0, 0, 5);
        put(1, WR, 6'd9, 1, 1, 6);
        tick();
        clr();
        wake(0, 6'd12, 0);
        tick();
        clr();
        tick();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL wake_blocked got %b want 00", o_iss_valid); end
        wake(1, 6'd12, 1);
        tick();
        clr();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL wake_early got %b want 00", o_iss_valid); end
        tick();
        vec++; if (o_iss_valid !== 2'b11 || o_iss_al_addr[0] !== AW'(5)
                   || o_iss_al_addr[1] !== AW'(6)) begin errs++;
            $display("FAIL wake_issue got %b al %0d,%0d want 11 al 5,6",
                     o_iss_valid, o_iss_al_addr[0], o_iss_al_addr[1]); end
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            vec++; if (o_disp_ready !== 1'b1) begin errs++;
                $display("FAIL full_fill%0d got %b want 1", c, o_disp_ready); end
            put(0, RD, (c == 0) ? 6'd21 : 6'd20, 0, 0, 10 + 2 * c);
            put(1, RD, 6'd20, 0, 0, 11 + 2 * c);
            tick();
        end
        clr();
        vec++; if (o_disp_ready !== 1'b0) begin errs++;
            $display("FAIL full_ready got %b want 0", o_disp_ready); end
        put(0, RD, 6'd1, 1, 0, 18);
        put(1, RD, 6'd1, 1, 0, 19);
        tick();
        clr();
        vec++; if (o_disp_ready !== 1'b0) begin errs++;
            $display("FAIL full_drop got %b want 0", o_disp_ready); end
        wake(0, 6'd21, 1);
        tick();
        clr();
        tick();
        vec++; if (o_iss_valid !== 2'b01 || o_iss_al_addr[0] !== AW'(10)) begin errs++;
            $display("FAIL full_head got %b al %0d want 01 al 10",
                     o_iss_valid, o_iss_al_addr[0]); end
        vec++; if (o_disp_ready !== 1'b0) begin errs++;
            $display("FAIL full_seven got %b want 0", o_disp_ready); end
        tick();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL full_stall got %b want 00", o_iss_valid); end
    endtask

    task automatic test_recall();
        do_reset();
        put(0, RD, 6'd30, 0, 0, 5);
        put(1, RD, 6'd30, 0, 0, 6);
        tick();
        put(0, RD, 6'd30, 0, 0, 7);
        put(1, RD, 6'd30, 0, 0, 8);
        tick();
        clr();
        if_recall = 1; new_front = AW'(7); old_front = AW'(9);
        put(0, RD, 6'd2, 1, 0, 9);
        tick();
        clr();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL recall_valid got %b want 00", o_iss_valid); end
        for (int c = 0; c < 3; c++) begin
            vec++; if (o_disp_ready !== 1'b1) begin errs++;
                $display("FAIL recall_space%0d got %b want 1", c, o_disp_ready); end
            put(0, RD, 6'd31, 0, 0, 7 + 2 * c);
            put(1, RD, 6'd31, 0, 0, 8 + 2 * c);
            tick();
        end
        clr();
        vec++; if (o_disp_ready !== 1'b0) begin errs++;
            $display("FAIL recall_count got %b want 0", o_disp_ready); end
        wake(0, 6'd30, 1);
        tick();
        clr();
        tick();
        vec++; if (o_iss_valid !== 2'b11 || o_iss_al_addr[0] !== AW'(5)
                   || o_iss_al_addr[1] !== AW'(6)) begin errs++;
            $display("FAIL recall_keep got %b al %0d,%0d want 11 al 5,6",
                     o_iss_valid, o_iss_al_addr[0], o_iss_al_addr[1]); end
        tick();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL recall_gone got %b want 00", o_iss_valid); end
    endtask

    task automatic test_recall_block();
        do_reset();
        put(0, RD, 6'd3, 1, 0, 1);
        tick();
        clr();
        if_recall = 1; new_front = AW'(3); old_front = AW'(3);
        put(0, RD, 6'd3, 1, 0, 2);
        tick();
        clr();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL rblk_hold got %b want 00", o_iss_valid); end
        tick();
        vec++; if (o_iss_valid !== 2'b01 || o_iss_al_addr[0] !== AW'(1)) begin errs++;
            $display("FAIL rblk_issue got %b al %0d want 01 al 1",
                     o_iss_valid, o_iss_al_addr[0]); end
        tick();
        vec++; if (o_iss_valid !== 2'b00) begin errs++;
            $display("FAIL rblk_nodisp got %b want 00", o_iss_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            clr();
            put((i % 3 == 2) ? 1 : 0, logic'(i % 2), 6'd4, 1, 1, i);
            tick();
            vec++;
            if (i == 0) begin
                if (o_iss_valid !== 2'b00) begin errs++;
                    $display("FAIL b2b_first got %b want 00", o_iss_valid); end
            end else if (o_iss_valid !== 2'b01 || o_iss_al_addr[0] !== AW'(i - 1)) begin
                errs++;
                $display("FAIL b2b_%0d got %b al %0d want 01 al %0d",
                         i, o_iss_valid, o_iss_al_addr[0], i - 1);
            end
        end
        clr();
        tick();
        vec++; if (o_iss_valid !== 2'b01 || o_iss_al_addr[0] !== AW'(19)) begin errs++;
            $display("FAIL b2b_last got %b al %0d want 01 al 19",
                     o_iss_valid, o_iss_al_addr[0]); end
    endtask

    function automatic bit hit(input logic [PW-1:0] t);
        for (int w = 0; w < 2; w++)
            if (i_wb_valid[w] && i_wb_uses_rd[w] && i_wb_rd[w] == t) return 1;
        return 0;
    endfunction

    function automatic bit ready_op(input op_t o);
        return o.r1 && (o.t == RD || o.r2);
    endfunction

    task automatic test_random();
        op_t q[$];
        op_t keep[$];
        op_t eo[2];
        op_t n;
        logic [1:0] ev;
        int next_al, k, nf, span, sz;
        bit rec;
        do_reset();
        next_al = 0;
        for (int c = 0; c < 400; c++) begin
            clr();
            rec = ($urandom_range(0, 15) == 0);
            nf = next_al;
            if (rec) begin
                k = $urandom_range(0, q.size());
                nf = (next_al - k + ALN) % ALN;
                if_recall = 1;
                new_front = AW'(nf);
                old_front = AW'(next_al);
            end
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(0, 2) != 0) begin
                    i_disp_valid[l]   = 1'b1;
                    i_disp_type[l]    = logic'($urandom_range(0, 1));
                    i_disp_rd[l]      = PW'($urandom_range(0, 63));
                    i_disp_rs1[l]     = PW'($urandom_range(0, 15));
                    i_disp_rs2[l]     = PW'($urandom_range(0, 15));
                    i_disp_rs1_rdy[l] = ($urandom_range(0, 3) != 0);
                    i_disp_rs2_rdy[l] = ($urandom_range(0, 3) != 0);
                    i_disp_imm[l]     = $urandom;
                end
                if ($urandom_range(0, 1) == 1)
                    wake(l, PW'($urandom_range(0, 15)), logic'($urandom_range(0, 3) != 0));
            end
            i_disp_al_addr[0] = AW'(next_al);
            i_disp_al_addr[1] = AW'(next_al + int'(i_disp_valid[0]));

            vec++;
            if (o_disp_ready !== ((DEPTH - q.size()) >= 2)) begin errs++;
                $display("FAIL rnd_ready c%0d got %b want %b",
                         c, o_disp_ready, (DEPTH - q.size()) >= 2); end

            sz = q.size();
            ev = '0;
            if (!rec && q.size() > 0 && ready_op(q[0])) begin
                eo[0] = q.pop_front(); ev[0] = 1;
                if (q.size() > 0 && ready_op(q[0])) begin
                    eo[1] = q.pop_front(); ev[1] = 1;
                end
            end
            foreach (q[i]) begin
                if (hit(q[i].rs1)) q[i].r1 = 1;
                if (hit(q[i].rs2)) q[i].r2 = 1;
            end
            if (rec) begin
                span = (next_al - nf + ALN) % ALN;
                keep.delete();
                foreach (q[i])
                    if (((int'(q[i].al) - nf + ALN) % ALN) >= span) keep.push_back(q[i]);
                q = keep;
                next_al = nf;
            end else if (DEPTH - sz >= 2) begin
                for (int l = 0; l < 2; l++) begin
                    if (i_disp_valid[l]) begin
                        n.t = i_disp_type[l]; n.rd = i_disp_rd[l];
                        n.rs1 = i_disp_rs1[l]; n.rs2 = i_disp_rs2[l];
                        n.r1 = i_disp_rs1_rdy[l] | hit(i_disp_rs1[l]);
                        n.r2 = i_disp_rs2_rdy[l] | hit(i_disp_rs2[l]);
                        n.imm = i_disp_imm[l]; n.al = AW'(next_al);
                        q.push_back(n);
                        next_al = (next_al + 1) % ALN;
                    end
                end
            end

            tick();
            vec++;
            if (o_iss_valid !== ev) begin errs++;
                $display("FAIL rnd_valid c%0d got %b want %b", c, o_iss_valid, ev); end
            for (int l = 0; l < 2; l++) begin
                if (ev[l]) begin
                    vec++;
                    if ({o_iss_type[l], o_iss_rd[l], o_iss_rs1[l], o_iss_rs2[l],
                         o_iss_imm[l], o_iss_al_addr[l]} !==
                        {eo[l].t, eo[l].rd, eo[l].rs1, eo[l].rs2, eo[l].imm, eo[l].al})
                    begin errs++;
                        $display("FAIL rnd_op c%0d lane%0d got al %0d imm %h want al %0d imm %h",
                                 c, l, o_iss_al_addr[l], o_iss_imm[l], eo[l].al, eo[l].imm);
                    end
                end
            end
        end
    endtask

    initial begin
        clr();
        rst_n = 1;
        #2;
        test_reset();
        test_reset_mid();
        test_dual_issue();
        test_wakeup();
        test_full();
        test_recall();
        test_recall_block();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
